// File: rtl/alu_multicycle_if.sv
// Valid/ready bundle between the ID/EX register, the execute ALU and the EX/MEM register.
interface alu_multicycle_if #(parameter int DATA_W = 64);
    logic              i_flush;
    logic              i_valid;
    logic              o_ready;
    logic [3:0]        i_ALUinst;
    logic [DATA_W-1:0] i_ALU_in1;
    logic [DATA_W-1:0] i_ALU_in2;
    logic              o_valid;
    logic              i_ready;
    logic [DATA_W-1:0] o_ALUresult;
    logic              o_Zero;

    modport master (
        output i_flush, i_valid, i_ALUinst, i_ALU_in1, i_ALU_in2, i_ready,
        input  o_ready, o_valid, o_ALUresult, o_Zero
    );

    modport slave (
        input  i_flush, i_valid, i_ALUinst, i_ALU_in1, i_ALU_in2, i_ready,
        output o_ready, o_valid, o_ALUresult, o_Zero
    );
endinterface

// File: rtl/alu_multicycle.sv
// Execute-stage ALU: single-cycle logic/arith/shift/compare ops plus iterative
// radix-2 mul/mulhu/divu/remu sharing one 2*DATA_W accumulator.
module alu_multicycle #(
    parameter int DATA_W = 64
) (
    input logic          i_clk,
    input logic          i_rst_n,
    alu_multicycle_if.slave bus
);
    localparam int SHAMT_W = $clog2(DATA_W);
    localparam int CNT_W   = $clog2(DATA_W) + 1;

    typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2} state_t;

    state_t              state_r, state_s;
    logic [CNT_W-1:0]    cnt_r, cnt_s;
    logic [1:0]          op_r, op_s;
    logic [DATA_W-1:0]   opnd_r, opnd_s;
    logic [2*DATA_W-1:0] acc_r, acc_s;
    logic [DATA_W-1:0]   result_r, result_s;
    logic                zero_r, zero_s;

    logic [DATA_W-1:0]   a_s, b_s, diff_s, alu_res_s;
    logic [SHAMT_W-1:0]  shamt_s;
    logic                alu_zero_s, is_iter_s;
    logic [DATA_W:0]     mul_sum_s, div_shift_s;
    logic [DATA_W-1:0]   div_rem_s;
    logic                div_ge_s;
    logic [2*DATA_W-1:0] step_s;

    // single-cycle datapath and branch flag
    always_comb begin
        a_s        = bus.i_ALU_in1;
        b_s        = bus.i_ALU_in2;
        shamt_s    = b_s[SHAMT_W-1:0];
        diff_s     = a_s - b_s;
        is_iter_s  = (bus.i_ALUinst[3:2] == 2'b11);
        alu_res_s  = '0;
        alu_zero_s = 1'b0;
        case (bus.i_ALUinst)
            4'b0000: alu_res_s = a_s & b_s;
            4'b0001: alu_res_s = a_s | b_s;
            4'b0010: alu_res_s = a_s + b_s;
            4'b0011: alu_res_s = a_s ^ b_s;
            4'b0100: alu_res_s = a_s << shamt_s;
            4'b0101: alu_res_s = a_s >> shamt_s;
            4'b0110: begin
                alu_res_s  = diff_s;
                alu_zero_s = (diff_s == '0);
            end
            4'b0111: begin
                alu_res_s  = diff_s;
                alu_zero_s = (diff_s != '0);
            end
            4'b1000: alu_res_s = $unsigned($signed(a_s) >>> shamt_s);
            4'b1001: alu_res_s = {{(DATA_W-1){1'b0}}, ($signed(a_s) < $signed(b_s))};
            4'b1010: alu_res_s = {{(DATA_W-1){1'b0}}, (a_s < b_s)};
            default: alu_res_s = '0;
        endcase
    end

    // one radix-2 iteration: mul keeps multiplier in the low half and shifts right,
    // divide keeps the partial remainder high and the quotient low, shifting left
    always_comb begin
        mul_sum_s   = {1'b0, acc_r[2*DATA_W-1:DATA_W]} +
                      (acc_r[0] ? {1'b0, opnd_r} : {(DATA_W+1){1'b0}});
        div_shift_s = {acc_r[2*DATA_W-1:DATA_W], acc_r[DATA_W-1]};
        div_ge_s    = (div_shift_s >= {1'b0, opnd_r});
        if (div_ge_s) begin
            div_rem_s = div_shift_s[DATA_W-1:0] - opnd_r;
        end else begin
            div_rem_s = div_shift_s[DATA_W-1:0];
        end
        if (op_r[1]) begin
            step_s = {div_rem_s, acc_r[DATA_W-2:0], div_ge_s};
        end else begin
            step_s = {mul_sum_s, acc_r[DATA_W-1:1]};
        end
    end

    // next-state and datapath-register update
    always_comb begin
        state_s  = state_r;
        cnt_s    = cnt_r;
        op_s     = op_r;
        opnd_s   = opnd_r;
        acc_s    = acc_r;
        result_s = result_r;
        zero_s   = zero_r;
        if (bus.i_flush) begin
            state_s  = IDLE;
            cnt_s    = '0;
            result_s = '0;
            zero_s   = 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (bus.i_valid && is_iter_s) begin
                        state_s = BUSY;
                        cnt_s   = '0;
                        op_s    = bus.i_ALUinst[1:0];
                        if (bus.i_ALUinst[1]) begin
                            opnd_s = b_s;
                            acc_s  = {{DATA_W{1'b0}}, a_s};
                        end else begin
                            opnd_s = a_s;
                            acc_s  = {{DATA_W{1'b0}}, b_s};
                        end
                    end else if (bus.i_valid) begin
                        state_s  = DONE;
                        result_s = alu_res_s;
                        zero_s   = alu_zero_s;
                    end else begin
                        state_s = IDLE;
                    end
                end
                BUSY: begin
                    acc_s = step_s;
                    cnt_s = cnt_r + CNT_W'(1);
                    if (cnt_r == CNT_W'(DATA_W - 1)) begin
                        state_s  = DONE;
                        zero_s   = 1'b0;
                        result_s = op_r[0] ? step_s[2*DATA_W-1:DATA_W] : step_s[DATA_W-1:0];
                    end else begin
                        state_s = BUSY;
                    end
                end
                DONE: begin
                    if (bus.i_ready) begin
                        state_s = IDLE;
                    end else begin
                        state_s = DONE;
                    end
                end
                default: state_s = IDLE;
            endcase
        end
    end

    // state and datapath registers
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_r  <= IDLE;
            cnt_r    <= '0;
            op_r     <= 2'b00;
            opnd_r   <= '0;
            acc_r    <= '0;
            result_r <= '0;
            zero_r   <= 1'b0;
        end else begin
            state_r  <= state_s;
            cnt_r    <= cnt_s;
            op_r     <= op_s;
            opnd_r   <= opnd_s;
            acc_r    <= acc_s;
            result_r <= result_s;
            zero_r   <= zero_s;
        end
    end

    assign bus.o_ready     = (state_r == IDLE);
    assign bus.o_valid     = (state_r == DONE);
    assign bus.o_ALUresult = result_r;
    assign bus.o_Zero      = zero_r;
endmodule

// File: tb/tb_alu_multicycle.sv
// Directed and randomized checks of alu_multicycle against an arithmetic reference model.
module tb_alu_multicycle;
    logic clk = 1'b0;
    logic rst_n;
    int   vectors = 0;
    int   miscompares = 0;

    alu_multicycle_if #(.DATA_W(64)) bus ();

    alu_multicycle #(.DATA_W(64)) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic void ref_model(input logic [3:0] op, input logic [63:0] a, input logic [63:0] b,
                                      output logic [63:0] r, output logic z);
        logic [127:0] p;
        logic [5:0]   sh;
        p  = {64'd0, a} * {64'd0, b};
        sh = b[5:0];
        z  = 1'b0;
        case (op)
            4'h0: r = a & b;
            4'h1: r = a | b;
            4'h2: r = a + b;
            4'h3: r = a ^ b;
            4'h4: r = a << sh;
            4'h5: r = a >> sh;
            4'h6: begin r = a - b; z = (r == 64'd0); end
            4'h7: begin r = a - b; z = (r != 64'd0); end
            4'h8: r = 64'($signed(a) >>> sh);
            4'h9: r = ($signed(a) < $signed(b)) ? 64'd1 : 64'd0;
            4'hA: r = (a < b) ? 64'd1 : 64'd0;
            4'hC: r = p[63:0];
            4'hD: r = p[127:64];
            4'hE: r = (b == 64'd0) ? {64{1'b1}} : a / b;
            4'hF: r = (b == 64'd0) ? a : a % b;
            default: r = 64'd0;
        endcase
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_op(input string tag, input logic [3:0] op, input logic [63:0] a, input logic [63:0] b);
        logic [63:0] er;
        logic        ez;
        int          lat;
        int          busy_rdy;
        logic        iter;
        ref_model(op, a, b, er, ez);
        iter = (op[3:2] == 2'b11);
        check({tag, " ready"}, 64'(bus.o_ready), 64'd1);
        bus.i_ALUinst = op;
        bus.i_ALU_in1 = a;
        bus.i_ALU_in2 = b;
        bus.i_valid   = 1'b1;
        bus.i_ready   = 1'b0;
        tick();
        bus.i_valid   = 1'b0;
        bus.i_ALU_in1 = {$urandom(), $urandom()};
        bus.i_ALU_in2 = {$urandom(), $urandom()};
        bus.i_ALUinst = 4'($urandom_range(0, 15));
        lat = 1;
        busy_rdy = 0;
        while (bus.o_valid !== 1'b1 && lat < 100) begin
            if (bus.o_ready !== 1'b0) busy_rdy++;
            tick();
            lat++;
        end
        check({tag, " latency"}, 64'(lat), iter ? 64'd65 : 64'd1);
        if (iter) check({tag, " busy_ready"}, 64'(busy_rdy), 64'd0);
        check({tag, " result"}, bus.o_ALUresult, er);
        check({tag, " zero"}, 64'(bus.o_Zero), 64'(ez));
        bus.i_ready = 1'b1;
        tick();
        bus.i_ready = 1'b0;
        check({tag, " valid_drop"}, 64'(bus.o_valid), 64'd0);
    endtask

    initial begin
        logic [63:0] hold_res;
        int          bad;
        logic [3:0]  rop;
        logic [63:0] ra, rb;

        rst_n         = 1'b0;
        bus.i_flush   = 1'b0;
        bus.i_valid   = 1'b0;
        bus.i_ready   = 1'b0;
        bus.i_ALUinst = 4'h0;
        bus.i_ALU_in1 = 64'd0;
        bus.i_ALU_in2 = 64'd0;
        #12;
        check("rst valid", 64'(bus.o_valid), 64'd0);
        check("rst result", bus.o_ALUresult, 64'd0);
        check("rst zero", 64'(bus.o_Zero), 64'd0);
        tick();
        rst_n = 1'b1;
        tick();

        // reset in the middle of a multiply
        run_op("add7_9", 4'h2, 64'd7, 64'd9);
        bus.i_ALUinst = 4'hC;
        bus.i_ALU_in1 = 64'd12345;
        bus.i_ALU_in2 = 64'd678;
        bus.i_valid   = 1'b1;
        tick();
        bus.i_valid = 1'b0;
        repeat (10) tick();
        rst_n = 1'b0;
        #1;
        check("midrst valid", 64'(bus.o_valid), 64'd0);
        check("midrst result", bus.o_ALUresult, 64'd0);
        tick();
        rst_n = 1'b1;
        tick();
        check("postrst ready", 64'(bus.o_ready), 64'd1);
        run_op("add2_3", 4'h2, 64'd2, 64'd3);
        check("add2_3 literal", bus.o_ALUresult, 64'd5);

        // directed single-cycle and boundary cases
        run_op("add_wrap", 4'h2, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1);
        run_op("sub_eq", 4'h6, 64'd5, 64'd5);
        run_op("sub_ne", 4'h7, 64'd5, 64'd5);
        run_op("slt", 4'h9, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1);
        run_op("sltu", 4'hA, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1);
        run_op("sra", 4'h8, 64'h8000_0000_0000_0000, 64'h41);
        check("sra literal", bus.o_ALUresult, 64'hC000_0000_0000_0000);
        run_op("sll", 4'h4, 64'h0000_0000_0000_0003, 64'h7F);
        run_op("srl", 4'h5, 64'h8000_0000_0000_0000, 64'h3F);
        run_op("rsvd", 4'hB, 64'hDEAD_BEEF, 64'h1234);

        // iterative ops
        run_op("mul", 4'hC, 64'h1_0000_0001, 64'h1_0000_0001);
        check("mul literal", bus.o_ALUresult, 64'h2_0000_0001);
        run_op("mulhu", 4'hD, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF);
        check("mulhu literal", bus.o_ALUresult, 64'hFFFF_FFFF_FFFF_FFFE);
        run_op("divu", 4'hE, 64'd100, 64'd7);
        check("divu literal", bus.o_ALUresult, 64'd14);
        run_op("remu", 4'hF, 64'd100, 64'd7);
        check("remu literal", bus.o_ALUresult, 64'd2);
        run_op("divu0", 4'hE, 64'd9, 64'd0);
        run_op("remu0", 4'hF, 64'd9, 64'd0);

        // backpressure: DONE holds, new request ignored until after i_ready
        bus.i_ALUinst = 4'h2;
        bus.i_ALU_in1 = 64'd40;
        bus.i_ALU_in2 = 64'd2;
        bus.i_valid   = 1'b1;
        tick();
        bus.i_ALUinst = 4'h3;
        bus.i_ALU_in1 = 64'hAA;
        bus.i_ALU_in2 = 64'h0F;
        hold_res = bus.o_ALUresult;
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            if (bus.o_valid !== 1'b1 || bus.o_ready !== 1'b0 || bus.o_ALUresult !== 64'd42) bad++;
            tick();
        end
        check("bp hold", 64'(bad), 64'd0);
        check("bp stable", bus.o_ALUresult, hold_res);
        bus.i_ready = 1'b1;
        tick();
        bus.i_ready = 1'b0;
        check("bp no_accept valid", 64'(bus.o_valid), 64'd0);
        check("bp no_accept ready", 64'(bus.o_ready), 64'd1);
        tick();
        bus.i_valid = 1'b0;
        check("bp next valid", 64'(bus.o_valid), 64'd1);
        check("bp next result", bus.o_ALUresult, 64'hA5);
        bus.i_ready = 1'b1;
        tick();
        bus.i_ready = 1'b0;

        // flush mid-divide and flush against a request in IDLE
        run_op("subne_pre", 4'h7, 64'd9, 64'd4);
        bus.i_ALUinst = 4'hE;
        bus.i_ALU_in1 = 64'd1000;
        bus.i_ALU_in2 = 64'd3;
        bus.i_valid   = 1'b1;
        tick();
        bus.i_valid = 1'b0;
        repeat (29) tick();
        bus.i_flush = 1'b1;
        tick();
        bus.i_flush = 1'b0;
        check("flush valid", 64'(bus.o_valid), 64'd0);
        check("flush ready", 64'(bus.o_ready), 64'd1);
        check("flush result", bus.o_ALUresult, 64'd0);
        check("flush zero", 64'(bus.o_Zero), 64'd0);
        bad = 0;
        for (int i = 0; i < 70; i++) begin
            if (bus.o_valid !== 1'b0) bad++;
            tick();
        end
        check("flush no_pulse", 64'(bad), 64'd0);
        bus.i_flush   = 1'b1;
        bus.i_valid   = 1'b1;
        bus.i_ALUinst = 4'h2;
        tick();
        bus.i_flush = 1'b0;
        bus.i_valid = 1'b0;
        check("flush_req valid", 64'(bus.o_valid), 64'd0);
        check("flush_req ready", 64'(bus.o_ready), 64'd1);
        run_op("xor", 4'h3, 64'hF0, 64'hFF);
        check("xor literal", bus.o_ALUresult, 64'h0F);

        // randomized operations against the reference model
        for (int i = 0; i < 40; i++) begin
            rop = 4'($urandom_range(0, 15));
            ra  = {$urandom(), $urandom()};
            rb  = {$urandom(), $urandom()};
            if ($urandom_range(0, 3) == 0) rb = 64'($urandom_range(0, 9));
            if ($urandom_range(0, 5) == 0) ra = rb;
            run_op($sformatf("rnd%0d_op%0h", i, rop), rop, ra, rb);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
